// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB handshakes, PC and retire count.
// Optional macro SEQ_TRAP_EN adds the TRAP state for illegal instructions and misaligned targets.
module core_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     instr_in,
  output logic [31:0]     ir,
  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_is_jump,
  input  logic            dec_writes_rd,
  input  logic            dec_illegal,
  output logic            ex_en,
  input  logic            ex_is_branch_out,
  input  logic [XLEN-1:0] ex_branch_result,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instret,
  output logic [2:0]      state,
  output logic            trap
);

  // state  | meaning
  // IDLE   | waiting for run
  // FETCH  | imem request held until imem_ack
  // DECODE | decode flags settle
  // EXEC   | ex_en strobe
  // MEM    | dmem request held until dmem_ack
  // WB     | writeback, pc/instret update
  // TRAP   | one-cycle trap pulse, pc <= TRAP_VECTOR
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  localparam logic [XLEN-1:0] ONE  = XLEN'(1);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instret;
  logic [31:0]     r_ir;

  logic            w_is_mem;
  logic            w_take;
  logic            w_wb_trap;
  logic            w_dec_trap;
  logic            w_wb_commit;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_next;

  // Targets are always word aligned; a misaligned request either traps or is silently rounded down.
  assign w_target = {ex_branch_result[XLEN-1:2], 2'b00};

`ifdef SEQ_TRAP_EN
  assign w_dec_trap = dec_illegal;
  assign w_is_mem   = dec_is_load | dec_is_store;
  assign w_take     = dec_is_jump | ex_is_branch_out;
  assign w_wb_trap  = w_take & (|ex_branch_result[1:0]);
  assign trap       = (r_state == S_TRAP);
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^ex_branch_result[1:0];
  assign w_dec_trap   = 1'b0;
  // Illegal instructions retire as NOPs: no memory access, no writeback, no redirect.
  assign w_is_mem     = (dec_is_load | dec_is_store) & ~dec_illegal;
  assign w_take       = (dec_is_jump | ex_is_branch_out) & ~dec_illegal;
  assign w_wb_trap    = 1'b0;
  assign trap         = 1'b0;
`endif

  assign w_pc_next   = w_take ? w_target : r_pc + FOUR;
  assign w_wb_commit = (r_state == S_WB) & ~w_wb_trap;

  always_comb begin
    w_next   = S_IDLE;
    imem_req = 1'b0;
    ex_en    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    case (r_state)
      S_IDLE:   w_next = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        imem_req = 1'b1;
        w_next   = imem_ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: w_next = w_dec_trap ? S_TRAP : S_EXEC;
      S_EXEC: begin
        ex_en  = 1'b1;
        w_next = w_is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_is_store;
        w_next   = dmem_ack ? S_WB : S_MEM;
      end
      S_WB: begin
        rf_we  = w_wb_commit & dec_writes_rd & ~dec_is_store & ~dec_illegal;
        w_next = w_wb_trap ? S_TRAP : (run ? S_FETCH : S_IDLE);
      end
      S_TRAP:   w_next = run ? S_FETCH : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_VECTOR;
      r_ir      <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && imem_ack) r_ir <= instr_in;
      if (w_wb_commit) begin
        r_pc      <= w_pc_next;
        r_instret <= r_instret + ONE;
      end
      if (r_state == S_TRAP) r_pc <= TRAP_VECTOR;
    end
  end

  assign state     = r_state;
  assign pc        = r_pc;
  assign imem_addr = r_pc;
  assign ir        = r_ir;
  assign instret   = r_instret;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus queues per-instruction expectations, monitor checks each WB.
// A second 8-bit instance shares the stimulus so pc/instret wraparound is reachable in a short run.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [31:0] instr_in = '0;
  logic        dec_is_load = 0, dec_is_store = 0, dec_is_jump = 0, dec_writes_rd = 0, dec_illegal = 0;
  logic        ex_is_branch_out = 0;
  logic [31:0] ex_branch_result = '0;

  logic        imem_req, ex_en, dmem_req, dmem_we, rf_we, trap;
  logic [31:0] imem_addr, ir, pc, instret;
  logic [2:0]  state;

  logic        s_imem_req, s_ex_en, s_dmem_req, s_dmem_we, s_rf_we, s_trap;
  logic [7:0]  s_imem_addr, s_pc, s_instret;
  logic [31:0] s_ir;
  logic [2:0]  s_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  core_sequencer u_dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .instr_in(instr_in), .ir(ir),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_is_jump(dec_is_jump),
    .dec_writes_rd(dec_writes_rd), .dec_illegal(dec_illegal),
    .ex_en(ex_en), .ex_is_branch_out(ex_is_branch_out), .ex_branch_result(ex_branch_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we),
    .pc(pc), .instret(instret), .state(state), .trap(trap)
  );

  core_sequencer #(.XLEN(8)) u_small (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(s_imem_req), .imem_addr(s_imem_addr), .imem_ack(imem_ack), .instr_in(instr_in), .ir(s_ir),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_is_jump(dec_is_jump),
    .dec_writes_rd(dec_writes_rd), .dec_illegal(dec_illegal),
    .ex_en(s_ex_en), .ex_is_branch_out(ex_is_branch_out), .ex_branch_result(ex_branch_result[7:0]),
    .dmem_req(s_dmem_req), .dmem_we(s_dmem_we), .dmem_ack(dmem_ack), .rf_we(s_rf_we),
    .pc(s_pc), .instret(s_instret), .state(s_state), .trap(s_trap)
  );

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] instret;
    int          cyc, imem_n, dmem_n, we_n, ex_n, rf_n;
    logic [2:0]  nxt;
  } exp_t;

  exp_t q[$];
  logic [31:0] m_pc = '0, m_instret = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n;
    n = 0;
    while (state !== s) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL wait_state: state=%0d expected %0d (timeout)", state, s);
        finish_run();
      end
    end
  endtask

  // One instruction; called at a negedge, returns at the negedge following WB.
  task automatic do_instr(input logic [31:0] word, input logic ld, input logic st, input logic jmp,
                          input logic wr, input logic ill, input logic br, input logic [31:0] tgt,
                          input int iw, input int dw, input logic drop);
    exp_t e;
    logic mem, take;
    run = 1'b1;
    dec_is_load = ld; dec_is_store = st; dec_is_jump = jmp; dec_writes_rd = wr; dec_illegal = ill;
    ex_is_branch_out = br; ex_branch_result = tgt;
    mem  = (ld | st) & ~ill;
    take = (jmp | br) & ~ill;
    e.ir      = word;
    e.pc      = take ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
    e.instret = m_instret + 32'd1;
    e.cyc     = 4 + iw + (mem ? 1 + dw : 0);
    e.imem_n  = 1 + iw;
    e.dmem_n  = mem ? 1 + dw : 0;
    e.we_n    = (mem && st) ? 1 + dw : 0;
    e.ex_n    = 1;
    e.rf_n    = (wr && !st && !ill) ? 1 : 0;
    e.nxt     = drop ? 3'd0 : 3'd1;
    q.push_back(e);
    m_pc = e.pc;
    m_instret = e.instret;
    wait_state(3'd1);
    instr_in = ~word;
    repeat (iw) @(negedge clk);
    instr_in = word;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    instr_in = ~word;
    if (drop) run = 1'b0;
    if (mem) begin
      wait_state(3'd4);
      repeat (dw) @(negedge clk);
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
    end
    wait_state(3'd5);
    @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  int   c_cyc, c_imem, c_dmem, c_we, c_ex, c_rf;
  logic wb_pend = 1'b0;
  logic [2:0]  prev_state = 3'd0;
  logic [31:0] prev_pc = '0;
  int   strobe_viol = 0, pc_viol = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        wb_pend = 1'b0;
        c_cyc = 0; c_imem = 0; c_dmem = 0; c_we = 0; c_ex = 0; c_rf = 0;
      end else begin
        if (pc !== prev_pc && prev_state != 3'd5 && prev_state != 3'd6) pc_viol++;
        if (wb_pend) begin
          wb_pend = 1'b0;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: WB with no expected entry, pc=0x%0h", pc);
          end else begin
            e = q.pop_front();
            chk("ir", ir, e.ir);
            chk("pc", pc, e.pc);
            chk("instret", instret, e.instret);
            chk("cycles", c_cyc, e.cyc);
            chk("imem_req_cycles", c_imem, e.imem_n);
            chk("dmem_req_cycles", c_dmem, e.dmem_n);
            chk("dmem_we_cycles", c_we, e.we_n);
            chk("ex_en_cycles", c_ex, e.ex_n);
            chk("rf_we_cycles", c_rf, e.rf_n);
            chk("state_after_wb", {29'd0, state}, {29'd0, e.nxt});
            chk("pc_8bit", {24'd0, s_pc}, {24'd0, e.pc[7:0]});
            chk("instret_8bit", {24'd0, s_instret}, {24'd0, e.instret[7:0]});
          end
        end
        if (state == 3'd1 && prev_state != 3'd1) begin
          c_cyc = 0; c_imem = 0; c_dmem = 0; c_we = 0; c_ex = 0; c_rf = 0;
        end
        if (state >= 3'd1 && state <= 3'd5) c_cyc++;
        c_imem += int'(imem_req);
        c_dmem += int'(dmem_req);
        c_we   += int'(dmem_we);
        c_ex   += int'(ex_en);
        c_rf   += int'(rf_we);
        if (state == 3'd5) wb_pend = 1'b1;
      end
      if ((int'(imem_req) + int'(dmem_req) + int'(ex_en) + int'(rf_we)) > 1) strobe_viol++;
      if (imem_req !== (state == 3'd1) || dmem_req !== (state == 3'd4) || ex_en !== (state == 3'd3)) strobe_viol++;
      if ((rf_we && state != 3'd5) || (dmem_we && !dmem_req) || trap !== 1'b0) strobe_viol++;
      prev_state = state;
      prev_pc    = pc;
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_pc", pc, 32'd0);
    chk("reset_ir", ir, 32'd0);
    chk("reset_instret", instret, 32'd0);
    chk("reset_strobes", {28'd0, imem_req, dmem_req, ex_en, rf_we}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ALU op, zero wait: 4 cycles, rf_we once, pc 0 -> 4
    do_instr(32'h0000_0013, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0);
    // load, imem 2 waits, dmem 3 waits: 10 cycles
    do_instr(32'h0000_2003, 1, 0, 0, 1, 0, 0, 32'h0, 2, 3, 0);
    // store: no rf_we even with writes_rd set
    do_instr(32'h0000_2023, 0, 1, 0, 1, 0, 0, 32'h0, 0, 1, 0);
    // branch taken to 0x40, then branch not taken
    do_instr(32'h0000_0063, 0, 0, 0, 0, 0, 1, 32'h40, 1, 0, 0);
    do_instr(32'h0000_1063, 0, 0, 0, 0, 0, 0, 32'h80, 0, 0, 0);
    // jump to misaligned target: low bits dropped
    do_instr(32'h0000_006F, 0, 0, 1, 1, 0, 0, 32'h0000_0123, 0, 0, 0);
    // jump to top of address space, then sequential wrap to 0
    do_instr(32'h0000_106F, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
    do_instr(32'h0000_0033, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0);
    // illegal with load+jump flags: NOP, pc+4, no rf_we, no MEM
    do_instr(32'hFFFF_FFFF, 1, 0, 1, 1, 1, 1, 32'h200, 0, 0, 0);
    // run dropped mid-instruction: completes, then IDLE
    do_instr(32'h0000_0093, 0, 0, 0, 1, 0, 0, 32'h0, 1, 0, 1);
    repeat (3) @(negedge clk);
    chk("idle_hold", {29'd0, state}, 32'd0);

    // reset while in MEM with dmem_req high; later acks ignored
    run = 1'b1;
    dec_is_load = 1; dec_is_store = 0; dec_is_jump = 0; dec_writes_rd = 1; dec_illegal = 0; ex_is_branch_out = 0;
    wait_state(3'd1);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    wait_state(3'd4);
    chk("mem_dmem_req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mem_state", {29'd0, state}, 32'd0);
    chk("rst_mem_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mem_pc", pc, 32'd0);
    chk("rst_mem_instret", instret, 32'd0);
    dmem_ack = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    imem_ack = 1'b0;
    chk("ack_after_rst_state", {29'd0, state}, 32'd0);
    chk("ack_after_rst_req", {30'd0, imem_req, dmem_req}, 32'd0);
    m_pc = '0;
    m_instret = '0;

    // 257 instructions: the 8-bit instance wraps instret 0xFF -> 0 and pc 0xFC -> 0
    for (int i = 0; i < 257; i++)
      do_instr(32'h1000_0000 + i, 0, 0, 0, i[0], 0, 0, 32'h0, 0, 0, 0);
    run = 1'b0;
    repeat (4) @(negedge clk);

    chk("queue_drained", q.size(), 32'd0);
    chk("strobe_violations", strobe_viol, 32'd0);
    chk("pc_change_violations", pc_viol, 32'd0);
    finish_run();
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 'h100, PC value loaded on trap.
REQ-004 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start/continue instruction sequencing.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address, equal to pc.
- imem_ack  in  1  fetch complete; instr_in valid.
- instr_in  in  32  fetched instruction.
- ir  out  32  latched instruction to decode.
- dec_is_load, dec_is_store, dec_is_jump, dec_writes_rd, dec_illegal  in  1 each  decode flags, valid in DECODE and later.
- ex_en  out  1  EX result capture strobe.
- ex_is_branch_out  in  1  EX branch-taken flag.
- ex_branch_result  in  XLEN  EX branch/jump target.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  store when 1, load when 0.
- dmem_ack  in  1  data access complete.
- rf_we  out  1  register-file write strobe.
- pc  out  XLEN  current program counter.
- instret  out  XLEN  retired-instruction count.
- state  out  3  FSM state encoding.
- trap  out  1  trap pulse.

Function
REQ-005 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; code 7 unused and SHALL go to IDLE.
REQ-006 IDLE: all strobes low; run=1 -> FETCH next cycle.
REQ-007 FETCH: imem_req=1 held until imem_ack=1; on ack cycle, ir<=instr_in and next state DECODE; imem_ack outside FETCH SHALL be ignored.
REQ-008 DECODE: one cycle, then EXEC; dec_illegal=1 handled per REQ-019/020.
REQ-009 EXEC: one cycle with ex_en=1; -> MEM if dec_is_load or dec_is_store, else WB.
REQ-010 MEM: dmem_req=1, dmem_we=dec_is_store, held until dmem_ack=1, then WB; dmem_ack outside MEM SHALL be ignored.
REQ-011 WB: one cycle; rf_we=dec_writes_rd, except for store; instret increments by 1 modulo 2^XLEN.
REQ-012 WB PC update: pc <= ex_branch_result if dec_is_jump or ex_is_branch_out, else pc+4 modulo 2^XLEN (0xFFFFFFFC -> 0).
REQ-013 After WB: run=1 -> FETCH, run=0 -> IDLE; run deasserting mid-instruction SHALL NOT abort it.
REQ-014 Zero-wait latency: ALU instruction FETCH->WB in 4 cycles; load/store 5 cycles; each ack wait cycle adds one.
REQ-015 Strobes imem_req, dmem_req, ex_en, rf_we SHALL be asserted only in their own states, never simultaneously.
REQ-016 pc SHALL change only in WB or TRAP, and in reset.

Reset
REQ-017 On rst=1 at a clock edge, the block SHALL enter IDLE, set pc=RESET_VECTOR, ir=0, instret=0, and drive all strobes and trap to 0, regardless of state or pending handshake.
REQ-018 A request aborted by reset SHALL NOT be re-issued until a new FETCH; an ack in the first cycle after reset SHALL be ignored.

Configuration
REQ-019 With SEQ_TRAP_EN defined: dec_illegal in DECODE, or a WB target with bits[1:0]!=0, SHALL go to TRAP instead of EXEC/WB writeback. In TRAP: trap=1 for one cycle, pc<=TRAP_VECTOR, no rf_we, no instret increment, then FETCH if run else IDLE.
REQ-020 Without SEQ_TRAP_EN: an illegal instruction SHALL execute as a NOP (EXEC, WB, no rf_we, no MEM, pc+4, instret increments); target bits[1:0] SHALL be forced to 0; trap tied to 0; TRAP state unreachable.

Verification
REQ-021 rst, then run=1, imem_ack immediate, ALU op with dec_writes_rd=1 -> states 1,2,3,5; rf_we for 1 cycle; pc 0->4; instret=1.
REQ-022 Load, imem_ack delayed 2 cycles, dmem_ack delayed 3 cycles -> imem_req high 3 cycles, dmem_req high 4 cycles, dmem_we=0, total 10 cycles.
REQ-023 Branch with ex_is_branch_out=1 and ex_branch_result=0x40 -> pc=0x40 after WB; with ex_is_branch_out=0 -> pc=0x4.
REQ-024 pc=0xFFFFFFFC non-branch, and instret=0xFFFFFFFF -> after WB pc=0, instret=0.
REQ-025 dec_illegal=1: with SEQ_TRAP_EN -> trap pulse, pc=0x100, rf_we never asserted; without -> pc+4, no trap.
REQ-026 rst asserted while in MEM with dmem_req=1 -> next cycle IDLE, dmem_req=0, pc=RESET_VECTOR; dmem_ack then ignored.
